bias_add_seq: RTL

- Sequences one layer pass through the stage's registered float_24_8 bias adder.
- Accepts a stream of neuron sums and fetches the matching bias from the external bias RAM by neuron index.
- Presents each aligned sum/bias pair to the adder, then captures adder results into an output FIFO with valid/ready backpressure.
- Sits between the stage's accumulator output and the activation stage. The adder is always enabled, so flow control is credit-based at the input.

---
 rtl/bias_add_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bias_add_seq.sv
// Bias-add sequencer: streams neuron sums through an external registered
// bias adder, pairing each with its bias-RAM word, into a credit-gated FIFO.
module bias_add_seq #(
  parameter int NUM_OUT    = 12,
  parameter int IDX_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sum_valid,
  input  logic [31:0]      sum_data,
  output logic             sum_ready,
  output logic             bias_rd_en,
  output logic [IDX_W-1:0] bias_rd_addr,
  input  logic [31:0]      bias_rd_data,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_result,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             v1_q, v2_q;
  logic             l1_q, l2_q;
  logic [31:0]      s1_q;
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic             mlast_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW:0]      used;
  logic             accept, last_in;
  logic             push, pop, empty, full;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit counts queued plus in-flight entries; a same-cycle pop is ignored.
  assign used = {1'b0, cnt_q} + (CW+1)'(v1_q) + (CW+1)'(v2_q);
  assign sum_ready = (state_q == RUN) && (used < (CW+1)'(FIFO_DEPTH));
  assign accept = sum_valid && sum_ready;
  assign last_in = (idx_q == IDX_W'(NUM_OUT - 1));

  assign bias_rd_en = accept;
  assign bias_rd_addr = idx_q;
  assign add_a = v1_q ? s1_q : '0;
  assign add_b = v1_q ? bias_rd_data : '0;

  assign push = v2_q;
  assign empty = (cnt_q == '0);
  assign full = (cnt_q == CW'(FIFO_DEPTH));
  assign pop = !empty && out_ready;

  assign out_valid = !empty;
  assign out_data = empty ? '0 : mem_q[rd_q];
  assign out_last = !empty && mlast_q[rd_q];
  assign busy = (state_q != IDLE);
  assign done = done_q;

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d = '0;
        end
      end
      RUN: begin
        if (accept) begin
          idx_d = idx_q + 1'b1;
          if (last_in) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!v1_q && !v2_q && pop && cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10: cnt_d = cnt_q + 1'b1;
      2'b01: cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      done_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      l1_q <= 1'b0;
      l2_q <= 1'b0;
      s1_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      done_q <= done_d;
      v1_q <= accept;
      v2_q <= v1_q;
      l2_q <= l1_q;
      if (accept) begin
        s1_q <= sum_data;
        l1_q <= last_in;
      end
      if (push) wr_q <= nxt(wr_q);
      if (pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= add_result;
      mlast_q[wr_q] <= l2_q;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset) !(push && full)
  );

endmodule
